// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, helpers and types for the parametrised FIFO.
//   DEF_DATA_W / DEF_DEPTH : default word width and entry count
//   cnt_w()                : width of the occupancy counter (0..DEPTH inclusive)
//   fifo_flags_t           : status flag bundle, convenient for monitors
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // One extra bit so the counter can hold DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_param_if.sv
// fifo_param_if: producer/consumer handshake bundle for fifo_param.
//   master : drives Wr_enable, Read_enable, data_in; observes data and status
//   slave  : the FIFO side (inputs/outputs mirrored)
interface fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int CW = cnt_w(DEPTH);

  logic              Wr_enable;
  logic              Read_enable;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output Wr_enable, Read_enable, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  Wr_enable, Read_enable, data_in,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W storage array for fifo_param.
//   clk   : write clock
//   we    : write strobe, stores wdata at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : combinational read data mem[raddr]
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock synchronous FIFO.
//   clk    : clock, all state updates on the rising edge
//   reset  : asynchronous active-high reset (release synchronously)
//   bus    : fifo_param_if.slave (write/read requests, data, count,
//            full/empty/almost flags, overflow/underflow pulses)
// Optional macro FIFO_FWFT_EN: first-word fall-through; data_out shows the
// head word combinationally while the FIFO is non-empty. Without it, an
// accepted read registers the head word into data_out (1-cycle latency).
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic         clk,
  input logic         reset,
  fifo_param_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              full, empty;
  logic              wr_acc, rd_acc;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A write into a full FIFO is still taken if a read frees a slot this cycle.
  assign wr_acc = bus.Wr_enable & (~full | bus.Read_enable);
  assign rd_acc = bus.Read_enable & ~empty;

  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = bus.Wr_enable & ~wr_acc;
    unf_d = bus.Read_enable & ~rd_acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

`ifdef FIFO_FWFT_EN
  // Gate with empty so stale or uninitialised memory never shows.
  assign bus.data_out = empty ? '0 : mem_rdata;
`else
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (rd_acc) data_d = mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign bus.data_out = data_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: self-checking bench for fifo_param (DATA_W=8, DEPTH=16).
// Reference model is a queue of words plus the FIFO's accept rules; it
// predicts count, flags, error pulses and data_out after every edge.
// Honours FIFO_FWFT_EN for the expected data_out behaviour.
module tb_fifo_param;
  import fifo_pkg::*;

  localparam int DW   = 8;
  localparam int DEP  = 16;
  localparam int AF   = DEP - 2;
  localparam int AE   = 2;

  logic clk;
  logic reset;

  fifo_param_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();

  fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_dout;
  logic          exp_ovf;
  logic          exp_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    fifo_flags_t obs_f, exp_f;
    int n;
    n = q.size();
    obs_f.full         = bus.full;
    obs_f.empty        = bus.empty;
    obs_f.almost_full  = bus.almost_full;
    obs_f.almost_empty = bus.almost_empty;
    obs_f.overflow     = bus.overflow;
    obs_f.underflow    = bus.underflow;
    exp_f.full         = (n == DEP);
    exp_f.empty        = (n == 0);
    exp_f.almost_full  = (n >= AF);
    exp_f.almost_empty = (n <= AE);
    exp_f.overflow     = exp_ovf;
    exp_f.underflow    = exp_unf;
    chk({tag, ".count"}, 32'(bus.count), 32'(n));
    chk({tag, ".flags"}, 32'(obs_f), 32'(exp_f));
    chk({tag, ".dout"},  32'(bus.data_out), 32'(exp_dout));
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  // One clock cycle with the given requests; model updated, outputs checked.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din,
                      input string tag);
    logic was_full, was_empty, w_ok, r_ok;
    bus.Wr_enable   = wr;
    bus.Read_enable = rd;
    bus.data_in     = din;
    was_full  = (q.size() == DEP);
    was_empty = (q.size() == 0);
    r_ok = rd && !was_empty;
    w_ok = wr && (!was_full || rd);
    @(posedge clk);
    if (r_ok) begin
`ifdef FIFO_FWFT_EN
      void'(q.pop_front());
`else
      exp_dout = q.pop_front();
`endif
    end
    if (w_ok) q.push_back(din);
`ifdef FIFO_FWFT_EN
    exp_dout = (q.size() != 0) ? q[0] : '0;
`endif
    exp_ovf = wr && !w_ok;
    exp_unf = rd && !r_ok;
    #1;
    bus.Wr_enable   = 1'b0;
    bus.Read_enable = 1'b0;
    check_all(tag);
  endtask

  initial begin
    reset           = 1'b1;
    bus.Wr_enable   = 1'b0;
    bus.Read_enable = 1'b0;
    bus.data_in     = '0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b0, 1'b0, 8'h00, "idle");

    // Fill with 0x00..0x0F, then a rejected 17th write, then drain.
    for (int i = 0; i < DEP; i++) step(1'b1, 1'b0, DW'(i), "fill");
    step(1'b1, 1'b0, 8'hAA, "overflow");
    step(1'b0, 1'b0, 8'h00, "ovf_clear");
    for (int i = 0; i < DEP; i++) step(1'b0, 1'b1, 8'h00, "drain");

    // Underflow on empty, then simultaneous write+read on empty.
    step(1'b0, 1'b1, 8'h00, "underflow");
    step(1'b1, 1'b1, 8'h55, "wr_rd_empty");
    step(1'b0, 1'b1, 8'h00, "read_55");
    step(1'b0, 1'b0, 8'h00, "idle2");

    // Full FIFO with simultaneous write+read; 0x77 must come out last.
    for (int i = 0; i < DEP; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 255)), "fill2");
    step(1'b1, 1'b1, 8'h77, "wr_rd_full");
    for (int i = 0; i < DEP; i++) step(1'b0, 1'b1, 8'h00, "drain2");
    chk("last_word_77", 32'(exp_dout == 8'h77), 32'(1));

    // Randomised traffic with varying read/write bias.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic w, r;
        w = ($urandom_range(0, 99) < (ph[0] ? 70 : 35));
        r = ($urandom_range(0, 99) < (ph[0] ? 35 : 70));
        step(w, r, DW'($urandom_range(0, 255)), "random");
      end
    end

    // Mid-stream async reset at count 5, asserted between edges.
    while (q.size() != 0) step(1'b0, 1'b1, 8'h00, "pre_drain");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'hC0 + i), "pre_reset");
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    #2 reset = 1'b0;
    step(1'b1, 1'b0, 8'h3C, "post_wr0");
    step(1'b1, 1'b0, 8'h4D, "post_wr1");
    step(1'b0, 1'b1, 8'h00, "post_rd0");
    step(1'b0, 1'b1, 8'h00, "post_rd1");
    step(1'b0, 1'b1, 8'h00, "post_unf");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
